// File: rtl/vector_issue_ctrl_if.sv
// Instruction handshake plus lane broadcast and register-file write bus of the
// vector issue sequencer.
interface vector_issue_ctrl_if #(
    parameter int els_p      = 32,
    parameter int vlen_p     = 8,
    parameter int vdw_p      = 32,
    parameter int op_width_p = 3
);
    localparam int vaw = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int law = (vlen_p > 1) ? $clog2(vlen_p) : 1;

    logic                  v_i;
    logic                  ready_o;
    logic [op_width_p-1:0] op_i;
    logic [vaw-1:0]        vd_i;
    logic [vaw-1:0]        vs1_i;
    logic [vaw-1:0]        vs2_i;
    logic [vdw_p-1:0]      scalar_i;

    logic                  issue_v_o;
    logic                  lane_start_o;
    logic [op_width_p-1:0] lane_op_o;
    logic [vdw_p-1:0]      lane_scalar_o;
    logic [vaw-1:0]        r0_vaddr_o;
    logic [vaw-1:0]        r1_vaddr_o;
    logic [law-1:0]        r_addr_o;
    logic                  w_en_o;
    logic [vaw-1:0]        w_vaddr_o;
    logic [law-1:0]        w_addr_o;
    logic                  done_o;
    logic                  busy_o;

    modport master (
        output v_i, op_i, vd_i, vs1_i, vs2_i, scalar_i,
        input  ready_o, issue_v_o, lane_start_o, lane_op_o, lane_scalar_o,
               r0_vaddr_o, r1_vaddr_o, r_addr_o, w_en_o, w_vaddr_o, w_addr_o,
               done_o, busy_o
    );

    modport slave (
        input  v_i, op_i, vd_i, vs1_i, vs2_i, scalar_i,
        output ready_o, issue_v_o, lane_start_o, lane_op_o, lane_scalar_o,
               r0_vaddr_o, r1_vaddr_o, r_addr_o, w_en_o, w_vaddr_o, w_addr_o,
               done_o, busy_o
    );
endinterface

// File: rtl/vector_issue_ctrl.sv
// Vector lane sequencer: issues B beats per instruction, tracks writebacks in a
// delay line matching the lane pipeline and stalls on RAW hazards.
module vector_issue_ctrl #(
    parameter int els_p        = 32,
    parameter int vlen_p       = 8,
    parameter int vdw_p        = 32,
    parameter int lanes_p      = 4,
    parameter int op_width_p   = 3,
    parameter int pipe_depth_p = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    vector_issue_ctrl_if.slave  bus
);
    localparam int beats       = vlen_p / lanes_p;
    localparam int vaw         = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int law         = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int last_beat_i = beats - 1;
    localparam logic [law-1:0] last_beat = last_beat_i[law-1:0];

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic           valid;
        logic [vaw-1:0] vd;
        logic [law-1:0] addr;
        logic           last;
    } wb_entry_t;

    state_e                state_q, state_d;
    logic [law-1:0]        count_q, count_d;
    logic [op_width_p-1:0] op_q;
    logic [vaw-1:0]        vd_q, vs1_q, vs2_q;
    logic [vdw_p-1:0]      scalar_q;
    wb_entry_t             pipe_q [pipe_depth_p];
    wb_entry_t             head;
    wb_entry_t             tail;

    logic hazard;
    logic any_valid;
    logic accept;
    logic beat_last;
    logic ready;
    logic issue_v;
    logic lane_start;
    logic [law-1:0] r_addr;

    assign beat_last = (count_q == last_beat);
    assign tail      = pipe_q[pipe_depth_p-1];

    // Only RAW is checked; in-order retirement makes WAW safe.
    always_comb begin
        hazard    = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < pipe_depth_p; i++) begin
            if (pipe_q[i].valid) begin
                any_valid = 1'b1;
                if ((pipe_q[i].vd == bus.vs1_i) || (pipe_q[i].vd == bus.vs2_i)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        accept     = 1'b0;
        ready      = 1'b0;
        issue_v    = 1'b0;
        lane_start = 1'b0;
        r_addr     = '0;
        case (state_q)
            IDLE: begin
                ready = !hazard;
                if (bus.v_i && !hazard) begin
                    accept  = 1'b1;
                    count_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue_v    = 1'b1;
                r_addr     = count_q;
                lane_start = (count_q == '0);
                if (beat_last) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + law'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head = '0;
        if (state_q == ISSUE) begin
            head.valid = 1'b1;
            head.vd    = vd_q;
            head.addr  = count_q;
            head.last  = beat_last;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            op_q     <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= '0;
        end else if (accept) begin
            op_q     <= bus.op_i;
            vd_q     <= bus.vd_i;
            vs1_q    <= bus.vs1_i;
            vs2_q    <= bus.vs2_i;
            scalar_q <= bus.scalar_i;
        end
    end

    // Delay line mirrors the lane EX/WB latency; the tail stage is the write port.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < pipe_depth_p; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= head;
            for (int i = 1; i < pipe_depth_p; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.ready_o       = ready;
    assign bus.issue_v_o     = issue_v;
    assign bus.lane_start_o  = lane_start;
    assign bus.r_addr_o      = r_addr;
    assign bus.lane_op_o     = op_q;
    assign bus.lane_scalar_o = scalar_q;
    assign bus.r0_vaddr_o    = vs1_q;
    assign bus.r1_vaddr_o    = vs2_q;
    assign bus.w_en_o        = tail.valid;
    assign bus.w_vaddr_o     = tail.vd;
    assign bus.w_addr_o      = tail.addr;
    assign bus.done_o        = tail.valid & tail.last;
    assign bus.busy_o        = (state_q == ISSUE) | any_valid;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Scoreboard bench for vector_issue_ctrl: a cycle-level reference model predicts
// beats, writes, ready and busy; a negedge monitor compares the DUT against it.
module tb_vector_issue_ctrl;
    localparam int els_p        = 32;
    localparam int vlen_p       = 8;
    localparam int vdw_p        = 32;
    localparam int lanes_p      = 4;
    localparam int op_width_p   = 3;
    localparam int pipe_depth_p = 2;
    localparam int nb           = vlen_p / lanes_p;

    typedef struct {
        int          cyc;
        int          addr;
        bit          start;
        int          op;
        logic [31:0] scalar;
        int          vs1;
        int          vs2;
    } beat_t;

    typedef struct {
        int cyc;
        int vd;
        int addr;
        bit done;
    } wr_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;

    beat_t beat_q[$];
    wr_t   wr_q[$];
    wr_t   pend[$];
    int    acc_list[$];
    int    next_free = 0;
    bit    exp_ready = 1'b1;
    int    n_checks  = 0;
    int    n_fail    = 0;
    beat_t mb;
    wr_t   mw;

    vector_issue_ctrl_if #(
        .els_p(els_p), .vlen_p(vlen_p), .vdw_p(vdw_p), .op_width_p(op_width_p)
    ) bus ();

    vector_issue_ctrl #(
        .els_p(els_p), .vlen_p(vlen_p), .vdw_p(vdw_p), .lanes_p(lanes_p),
        .op_width_p(op_width_p), .pipe_depth_p(pipe_depth_p)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // An instruction may issue once the previous one has finished its beats and
    // no unretired write (including one writing this cycle) targets a source.
    function automatic bit model_ready(input int c, input int vs1, input int vs2);
        if (c < next_free) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].cyc >= c && (pend[i].vd == vs1 || pend[i].vd == vs2)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_busy(input int c);
        foreach (acc_list[i]) begin
            if (c >= acc_list[i] + 1 && c <= acc_list[i] + nb + pipe_depth_p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_accept(input int t, input int op, input int vd, input int vs1,
                                input int vs2, input logic [31:0] scalar);
        for (int k = 0; k < nb; k++) begin
            beat_q.push_back('{cyc: t + 1 + k, addr: k, start: (k == 0), op: op,
                               scalar: scalar, vs1: vs1, vs2: vs2});
            wr_q.push_back('{cyc: t + 1 + k + pipe_depth_p, vd: vd, addr: k, done: (k == nb - 1)});
            pend.push_back('{cyc: t + 1 + k + pipe_depth_p, vd: vd, addr: k, done: (k == nb - 1)});
        end
        acc_list.push_back(t);
        next_free = t + nb + 1;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        bus.v_i      = 1'b0;
        bus.op_i     = op_width_p'($urandom);
        bus.vd_i     = 5'($urandom_range(0, 15));
        bus.vs1_i    = 5'($urandom_range(0, 15));
        bus.vs2_i    = 5'($urandom_range(0, 15));
        bus.scalar_i = $urandom;
        exp_ready    = model_ready(cyc, int'(bus.vs1_i), int'(bus.vs2_i));
    endtask

    task automatic apply_stimulus(input int op, input int vd, input int vs1, input int vs2,
                                  input logic [31:0] scalar, input int gap);
        bit accepted = 1'b0;
        for (int g = 0; g < gap; g++) idle_cycle();
        for (int w = 0; w < 64 && !accepted; w++) begin
            @(posedge clk);
            #1;
            bus.v_i      = 1'b1;
            bus.op_i     = op_width_p'(op);
            bus.vd_i     = 5'(vd);
            bus.vs1_i    = 5'(vs1);
            bus.vs2_i    = 5'(vs2);
            bus.scalar_i = scalar;
            exp_ready    = model_ready(cyc, vs1, vs2);
            if (exp_ready) begin
                model_accept(cyc, op, vd, vs1, vs2, scalar);
                accepted = 1'b1;
            end
        end
        if (!accepted) check_output("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        bus.v_i = 1'b1;
        reset_n = 1'b0;
        beat_q.delete();
        wr_q.delete();
        pend.delete();
        acc_list.delete();
        next_free = 0;
        exp_ready = 1'b1;
        #1;
        check_output("rst_ready", bus.ready_o, 1);
        check_output("rst_issue_v", bus.issue_v_o, 0);
        check_output("rst_lane_start", bus.lane_start_o, 0);
        check_output("rst_lane_op", bus.lane_op_o, 0);
        check_output("rst_lane_scalar", bus.lane_scalar_o, 0);
        check_output("rst_r0_vaddr", bus.r0_vaddr_o, 0);
        check_output("rst_r1_vaddr", bus.r1_vaddr_o, 0);
        check_output("rst_r_addr", bus.r_addr_o, 0);
        check_output("rst_w_en", bus.w_en_o, 0);
        check_output("rst_w_vaddr", bus.w_vaddr_o, 0);
        check_output("rst_w_addr", bus.w_addr_o, 0);
        check_output("rst_done", bus.done_o, 0);
        check_output("rst_busy", bus.busy_o, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            exp_ready = 1'b1;
        end
        reset_n   = 1'b1;
        bus.v_i   = 1'b0;
        exp_ready = model_ready(cyc, int'(bus.vs1_i), int'(bus.vs2_i));
    endtask

    always @(negedge clk) begin
        check_output("ready", bus.ready_o, exp_ready);
        check_output("busy", bus.busy_o, model_busy(cyc));
        if (bus.issue_v_o) begin
            if (beat_q.size() == 0) begin
                check_output("unexpected_beat", bus.issue_v_o, 0);
            end else begin
                mb = beat_q.pop_front();
                check_output("beat_cycle", cyc, mb.cyc);
                check_output("r_addr", bus.r_addr_o, mb.addr);
                check_output("lane_start", bus.lane_start_o, mb.start);
                check_output("lane_op", bus.lane_op_o, mb.op);
                check_output("lane_scalar", bus.lane_scalar_o, mb.scalar);
                check_output("r0_vaddr", bus.r0_vaddr_o, mb.vs1);
                check_output("r1_vaddr", bus.r1_vaddr_o, mb.vs2);
            end
        end else begin
            check_output("lane_start_idle", bus.lane_start_o, 0);
            if (beat_q.size() != 0 && beat_q[0].cyc <= cyc) begin
                mb = beat_q.pop_front();
                check_output("missing_beat", bus.issue_v_o, 1);
            end
        end
        if (bus.w_en_o) begin
            if (wr_q.size() == 0) begin
                check_output("unexpected_write", bus.w_en_o, 0);
            end else begin
                mw = wr_q.pop_front();
                check_output("write_cycle", cyc, mw.cyc);
                check_output("w_vaddr", bus.w_vaddr_o, mw.vd);
                check_output("w_addr", bus.w_addr_o, mw.addr);
                check_output("done", bus.done_o, mw.done);
            end
        end else begin
            check_output("done_without_write", bus.done_o, 0);
            if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
                mw = wr_q.pop_front();
                check_output("missing_write", bus.w_en_o, 1);
            end
        end
    end

    initial begin
        bus.v_i      = 1'b0;
        bus.op_i     = '0;
        bus.vd_i     = '0;
        bus.vs1_i    = '0;
        bus.vs2_i    = '0;
        bus.scalar_i = '0;
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        exp_ready = model_ready(cyc, 0, 0);

        // Single instruction followed by an independent one with v_i held.
        apply_stimulus(3, 5, 1, 2, 32'hA5, 1);
        apply_stimulus(1, 6, 7, 8, 32'h1234, 0);
        for (int i = 0; i < 6; i++) idle_cycle();

        // RAW on vs1, RAW on vs2 only, then WAW only.
        apply_stimulus(3, 5, 1, 2, 32'hA5, 0);
        apply_stimulus(2, 9, 5, 3, 32'h77, 0);
        for (int i = 0; i < 6; i++) idle_cycle();
        apply_stimulus(3, 5, 1, 2, 32'hA5, 0);
        apply_stimulus(4, 10, 9, 5, 32'h55, 0);
        for (int i = 0; i < 6; i++) idle_cycle();
        apply_stimulus(3, 5, 1, 2, 32'hA5, 0);
        apply_stimulus(5, 5, 11, 12, 32'h66, 0);
        for (int i = 0; i < 6; i++) idle_cycle();

        // Reset during the second beat discards the instruction.
        apply_stimulus(3, 5, 1, 2, 32'hA5, 0);
        idle_cycle();
        do_reset(1);
        apply_stimulus(3, 5, 1, 2, 32'hA5, 1);
        for (int i = 0; i < 6; i++) idle_cycle();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom_range(0, 2));
            end else begin
                apply_stimulus($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom, $urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 10; i++) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
